// File: rtl/m_div_controller.sv
// m_div_controller: sequencing FSM for the M-unit restoring divider.
// Runs DIV/DIVU/REM/REMU by steering the remainder (R), divisor (D) and
// quotient (Z) select codes of an external datapath. It then forms the final
// result from the datapath registers, the divide-by-zero/overflow flags and
// the operand signs.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// start_valid/start_ready accept an operation. result_valid/result_ready
// return it. While valid is high and ready is low, the payload (result) is
// held stable.
//
// Optional build macro: M_DIV_RESULT_CACHE_EN. It reuses the retained datapath
// registers when the same operands and signedness are presented again, so a
// DIV followed by a REM costs one cycle.
module m_div_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  output logic [1:0]      mux_R,
  output logic [1:0]      mux_D,
  output logic [1:0]      mux_Z,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] R_KEEP = 2'd0, R_A = 2'd1, R_A_NEG = 2'd2, R_SUB_KEEP = 2'd3;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL_ADD = 2'd2;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_rem_q, signed_q, neg1_q, neg2_q, div0_q, ovf_q;
  logic [XLEN-1:0]   spec_a_q;

  logic accept, in_signed, in_div0, in_ovf, in_special, cache_hit;

  assign accept     = start_valid && start_ready;
  assign in_signed  = ~op[0];
  assign in_div0    = (rs2 == '0);
  assign in_ovf     = in_signed && (rs1 == MIN_NEG) && (rs2 == '1);
  assign in_special = in_div0 || in_ovf;
  assign dbg_state  = state_q;

`ifdef M_DIV_RESULT_CACHE_EN
  logic [XLEN-1:0] last_rs1_q, last_rs2_q;
  logic            last_signed_q, last_vld_q;

  assign cache_hit = last_vld_q && !in_special && (rs1 == last_rs1_q) &&
                     (rs2 == last_rs2_q) && (in_signed == last_signed_q);

  // Track the operands whose magnitudes are currently held in the datapath.
  // A special accept still loads R/D/Z, so it invalidates the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_rs1_q    <= '0;
      last_rs2_q    <= '0;
      last_signed_q <= 1'b0;
      last_vld_q    <= 1'b0;
    end else if (accept) begin
      if (in_special) begin
        last_vld_q <= 1'b0;
      end else begin
        last_rs1_q    <= rs1;
        last_rs2_q    <= rs2;
        last_signed_q <= in_signed;
        last_vld_q    <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register, operation flags and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      signed_q <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      spec_a_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_rem_q <= op[1];
        signed_q <= in_signed;
        neg1_q   <= rs1[XLEN-1];
        neg2_q   <= rs2[XLEN-1];
        div0_q   <= in_div0;
        ovf_q    <= in_ovf;
        spec_a_q <= rs1;
        cnt_q    <= '0;
      end else if (state_q == S_ITER) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic and datapath select codes.
  always_comb begin
    state_d      = state_q;
    mux_R        = R_KEEP;
    mux_D        = D_KEEP;
    mux_Z        = Z_KEEP;
    start_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = !reset;
        if (accept) begin
          if (!cache_hit) begin
            mux_R = (in_signed && rs1[XLEN-1]) ? R_A_NEG : R_A;
            mux_D = (in_signed && rs2[XLEN-1]) ? D_B_NEG : D_B;
            mux_Z = Z_ZERO;
          end
          state_d = (in_special || cache_hit) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        busy  = 1'b1;
        mux_R = R_SUB_KEEP;
        mux_D = D_SHR;
        mux_Z = Z_SHL_ADD;
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Final result: special cases first, then sign fix-up of the magnitudes.
  always_comb begin
    result = '0;
    if (state_q == S_DONE) begin
      if (div0_q)
        result = is_rem_q ? spec_a_q : '1;
      else if (ovf_q)
        result = is_rem_q ? '0 : MIN_NEG;
      else if (!is_rem_q)
        result = (signed_q && (neg1_q ^ neg2_q)) ? -quo_in : quo_in;
      else
        result = (signed_q && neg1_q) ? -rem_in : rem_in;
    end
  end

endmodule

// File: tb/tb_m_div_controller.sv
// tb_m_div_controller: drives m_div_controller against a behavioural restoring
// divider datapath and checks results against plain-arithmetic RISC-V
// division semantics.
module tb_m_div_controller;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start_valid = 1'b0, start_ready;
  logic [1:0]        op = 2'd0;
  logic [XLEN-1:0]   rs1 = '0, rs2 = '0;
  logic [XLEN-1:0]   rem_in, quo_in;
  logic [1:0]        mux_R, mux_D, mux_Z, dbg_state;
  logic              busy, result_valid;
  logic              result_ready = 1'b0;
  logic [XLEN-1:0]   result;

  m_div_controller #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .rs1(rs1), .rs2(rs2),
    .rem_in(rem_in), .quo_in(quo_in),
    .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .dbg_state(dbg_state)
  );

  // ---------------- datapath model ----------------
  // 64-bit divisor register starts at |b| << 31 and shifts right; each step
  // subtracts when it fits and shifts the outcome bit into Z.
  logic [31:0] dp_r = '0, dp_z = '0;
  logic [63:0] dp_d = '0;
  logic        dp_ge;
  logic [31:0] neg_rs1, neg_rs2;
  assign dp_ge   = ({32'b0, dp_r} >= dp_d);
  assign neg_rs1 = -rs1;
  assign neg_rs2 = -rs2;
  assign rem_in  = dp_r;
  assign quo_in  = dp_z;

  always @(posedge clk) begin
    case (mux_R)
      2'd1: dp_r <= rs1;
      2'd2: dp_r <= neg_rs1;
      2'd3: if (dp_ge) dp_r <= dp_r - dp_d[31:0];
      default: ;
    endcase
    case (mux_D)
      2'd1: dp_d <= {1'b0, rs2, 31'b0};
      2'd2: dp_d <= {1'b0, neg_rs2, 31'b0};
      2'd3: dp_d <= dp_d >> 1;
      default: ;
    endcase
    case (mux_Z)
      2'd1: dp_z <= '0;
      2'd2: dp_z <= {dp_z[30:0], dp_ge};
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0: r = $signed(a) / $signed(b);
      2'd1: r = a / b;
      2'd2: r = $signed(a) % $signed(b);
      default: r = a % b;
    endcase
    return r;
  endfunction

  // Retire the expected entry on each result handshake.
  always @(posedge clk) begin
    if (!reset && result_valid && result_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  // Per-cycle compare, sampled mid-low-phase after the driver has settled.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check("ready_vs_busy", {31'b0, start_ready}, {31'b0, ~busy});
      if (result_valid) begin
        if (exp_q.size() == 0) check("unexpected_result_valid", 32'd1, 32'd0);
        else check("result", result, exp_q[0]);
        check("done_sel", {26'b0, mux_R, mux_D, mux_Z}, 32'd0);
      end else begin
        check("result_idle", result, 32'd0);
        if (busy) check("iter_sel", {26'b0, mux_R, mux_D, mux_Z}, {26'b0, 2'd3, 2'd3, 2'd2});
      end
    end
  end

  // ---------------- driver ----------------
  logic        c_vld = 1'b0, c_s = 1'b0;
  logic [31:0] c_a = '0, c_b = '0;

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] got, output int lat);
    logic special, hit;
    logic [31:0] exp;
    special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef M_DIV_RESULT_CACHE_EN
    hit = !special && c_vld && a == c_a && b == c_b && (!o[0]) == c_s;
`else
    hit = 1'b0;
`endif
    exp = ref_result(o, a, b);
    @(negedge clk);
    start_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    #1;
    check("start_ready", {31'b0, start_ready}, 32'd1);
    check("accept_mux_R", {30'b0, mux_R}, hit ? 32'd0 : ((!o[0] && a[31]) ? 32'd2 : 32'd1));
    check("accept_mux_D", {30'b0, mux_D}, hit ? 32'd0 : ((!o[0] && b[31]) ? 32'd2 : 32'd1));
    check("accept_mux_Z", {30'b0, mux_Z}, hit ? 32'd0 : 32'd1);
    exp_q.push_back(exp);
    if (special) c_vld = 1'b0;
    else begin c_vld = 1'b1; c_a = a; c_b = b; c_s = !o[0]; end
    lat = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      start_valid = 1'b0;
      rs1 = $urandom; rs2 = $urandom;
      lat++;
      if (result_valid) break;
      if (lat >= 100) begin
        check("result_valid_timeout", 32'd0, 32'd1);
        break;
      end
    end
    check("latency", lat, (special || hit) ? 32'd1 : 32'd33);
    got = result;
    check("op_result", got, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, result_valid}, 32'd1);
      check("hold_result", result, got);
      check("hold_start_ready", {31'b0, start_ready}, 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    #1;
    check("post_valid", {31'b0, result_valid}, 32'd0);
    check("post_start_ready", {31'b0, start_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got, a, b, pa, pb;
    logic [1:0]  o;
    int lat;
    pa = 32'd100; pb = 32'd7;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_sel", {26'b0, mux_R, mux_D, mux_Z}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_start_ready", {31'b0, start_ready}, 32'd1);

    // Directed cases with hand-computed answers.
    run_op(2'd1, 32'd100, 32'd7, 0, got, lat);              check("divu_100_7", got, 32'd14);
    run_op(2'd3, 32'd100, 32'd7, 0, got, lat);              check("remu_100_7", got, 32'd2);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, got, lat);        check("div_m7_2", got, 32'hFFFF_FFFD);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, got, lat);        check("rem_m7_2", got, 32'hFFFF_FFFF);
    run_op(2'd1, 32'd5, 32'd0, 0, got, lat);                check("divu_by0", got, 32'hFFFF_FFFF);
    check("divu_by0_lat", lat, 32'd1);
    run_op(2'd2, 32'd5, 32'd0, 0, got, lat);                check("rem_by0", got, 32'd5);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, got, lat); check("div_ovf", got, 32'h8000_0000);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, got, lat); check("rem_ovf", got, 32'd0);
    check("rem_ovf_lat", lat, 32'd1);
    run_op(2'd0, 32'd1000, 32'hFFFF_FFFD, 5, got, lat);     check("div_hold", got, 32'hFFFF_FEB3);

    // Back-to-back DIV then REM on the same operands.
    run_op(2'd0, 32'd100, 32'd7, 0, got, lat);              check("div_100_7", got, 32'd14);
    run_op(2'd2, 32'd100, 32'd7, 0, got, lat);              check("rem_100_7", got, 32'd2);
`ifdef M_DIV_RESULT_CACHE_EN
    check("rem_repeat_lat", lat, 32'd1);
`else
    check("rem_repeat_lat", lat, 32'd33);
`endif

    // Reset in the middle of an operation.
    @(negedge clk);
    start_valid = 1'b1; op = 2'd1; rs1 = 32'd1000; rs2 = 32'd3;
    exp_q.push_back(32'd333);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_state", {30'b0, dbg_state}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    c_vld = 1'b0;
    #1;
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    check("mid_rst_start_ready", {31'b0, start_ready}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_valid", {31'b0, result_valid}, 32'd0);
    check("mid_rst_sel", {26'b0, mux_R, mux_D, mux_Z}, 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_result", {31'b0, result_valid}, 32'd0);

    // Randomized operations, with repeats to exercise operand reuse.
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; o[0] = 1'b0; end
        2, 3: begin a = pa; b = pb; end
        4, 5: begin a = $urandom; b = 32'($urandom_range(1, 20)); end
        6: begin a = $urandom; b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(o, a, b, $urandom_range(0, 3), got, lat);
      pa = a; pb = b;
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
